auth_request_arbiter: RTL and testbench
=======================================

// Module: auth_request_arbiter
// PURPOSE
//  N-channel successor to the two-source (PD/DEBUG) authentication request path. Round-robin arbitrates
//  8-bit request descriptors, dispatches each to the responder or initiator engine, frames the result
//  (USB control or plain), presents it downstream with ack timeout and bounded retry.
//  Sits between the requester queues (PD, DEBUG, ...) and the auth message transport.
// PARAMETERS
//  N_CH        2    number of requester channels (2..8)
//  HDR_W       32   engine header width, bits
//  PAY_W       256  engine payload width, bits
//  ACK_TO      1024 cycles to wait for engine done or msg_ack before expiry (>=2)
//  MAX_RETRY   2    re-presentations of a message after ack expiry (0..7)
// PORTS
//  clk          in   1              rising-edge clock, only clock
//  reset        in   1              synchronous, active-high
//  req_valid    in   N_CH           channel c has a pending descriptor
//  req_desc     in   8*N_CH         desc[c*8+:8] = {slot[7:6],role[5:4],usb[3:2],type[1:0]}
//  req_erase    out  N_CH           one-cycle one-hot pulse: descriptor of channel c consumed
//  resp_en      out  1              start/hold responder engine
//  init_en      out  1              start/hold initiator engine
//  eng_slot     out  2              latched slot field, valid while *_en high
//  eng_type     out  2              latched type field, valid while *_en high
//  eng_done     in   1              selected engine result valid this cycle
//  eng_hdr      in   HDR_W          engine header, sampled with eng_done
//  eng_pay      in   PAY_W          engine payload, sampled with eng_done
//  eng_bmrt     in   8              bmRequestType, sampled with eng_done
//  eng_breq     in   8              bRequest, sampled with eng_done
//  eng_wlen     in   16             wLength, sampled with eng_done
//  msg_out      out  32+HDR_W+PAY_W framed message, stable while msg_valid
//  msg_valid    out  1              message presented downstream
//  msg_ack      in   1              downstream accepts (counts only while msg_valid)
//  active_ch    out  $clog2(N_CH)   channel being served (meaningful outside IDLE)
//  err_role     out  1              one-cycle pulse: role field 00 or 11, request dropped
//  err_timeout  out  1              one-cycle pulse: engine or ack expiry, retries exhausted
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timer=0, retries=0, rr_ptr=N_CH-1 (channel 0 wins first).
//  States IDLE, DECODE, ENGINE, SEND, GAP, all registered; one-hot FSM.
//  IDLE: any req_valid -> grant first set bit searching rr_ptr+1 upward, wrapping modulo N_CH;
//   latch desc, active_ch=grant, req_erase[grant]=1 for exactly this cycle -> DECODE.
//  DECODE (1 cycle): role 01 -> resp_en=1; role 10 -> init_en=1; both -> ENGINE, timer=0.
//   Role 00/11 -> err_role pulse, rr_ptr=grant -> IDLE.
//  ENGINE: en held high until eng_done; on eng_done latch eng_* buses, en=0 next cycle -> SEND.
//   timer==ACK_TO-1 without done -> en=0, err_timeout pulse, rr_ptr=grant -> IDLE.
//  SEND: msg_valid=1; usb!=00 -> msg_out={bmrt,breq,hdr,wlen,pay};
//   usb==00 -> msg_out={32'b0,hdr,pay}. msg_out fixed from first SEND cycle until exit.
//   msg_ack&&msg_valid -> msg_valid=0 next cycle, rr_ptr=grant -> IDLE.
//   timer==ACK_TO-1, no ack: retries<MAX_RETRY -> retries++, timer=0 -> GAP;
//   else err_timeout pulse -> IDLE.
//  GAP: msg_valid=0 for exactly 1 cycle -> SEND (same msg_out).
//  Ack and expiry in the same cycle: ack wins, no error.
//  Latency: request -> erase 1 cycle; done -> msg_valid 1 cycle; ack -> next grant >=2 cycles.
//  Timer: $clog2(ACK_TO)-bit, cleared on every state entry; never wraps.
//  req_valid/desc changes after grant are ignored; a channel is not re-granted until IDLE.
//  Reset mid-operation: abandons transaction, no erase/error pulse, returns to reset values.
// STRUCTURE
//  Shared package: descriptor field offsets, ROLE_RESP=2'b01, ROLE_INIT=2'b10, USB_NONE=2'b00,
//   FSM state encodings, MSG_W = 32+HDR_W+PAY_W.
//  Sub-module rr_arbiter (N_CH request vector + rr_ptr -> one-hot grant + index), combinational.
// TESTING
//  1. ch0 role=01 usb=01, done after 3 cycles, ack 2 cycles later -> erase[0] 1 cycle,
//     resp_en 3 cycles, msg_out={bmrt,breq,hdr,wlen,pay}, msg_valid 2 cycles.
//  2. N_CH=4, all valid held -> grants 0,1,2,3,0 in order; erase one-hot each time.
//  3. role=11 -> err_role pulse, erase pulsed, no *_en, back to IDLE next cycle.
//  4. ACK_TO=8, MAX_RETRY=2, never ack -> 3 presentations, 1-cycle gaps, err_timeout once.
//  5. ack in expiry cycle -> no retry, no error; init role usb=00 -> top 32 bits zero.
//  6. reset during SEND -> msg_valid=0 next edge, channel 0 granted first after release.

Source files
------------

// File: rtl/auth_request_arbiter_pkg.sv
// Shared definitions for the authentication request arbiter: descriptor
// layout, role/usb codes, one-hot FSM encodings and message width helper.
package auth_request_arbiter_pkg;

  // Descriptor layout: {slot[7:6], role[5:4], usb[3:2], type[1:0]}
  localparam int SLOT_LSB = 6;
  localparam int ROLE_LSB = 4;
  localparam int USB_LSB  = 2;
  localparam int TYPE_LSB = 0;

  localparam logic [1:0] ROLE_RESP = 2'b01;
  localparam logic [1:0] ROLE_INIT = 2'b10;
  localparam logic [1:0] USB_NONE  = 2'b00;

  // One-hot FSM encodings
  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_DECODE = 5'b00010;
  localparam logic [4:0] ST_ENGINE = 5'b00100;
  localparam logic [4:0] ST_SEND   = 5'b01000;
  localparam logic [4:0] ST_GAP    = 5'b10000;

  // Framed message: 32 bits of USB control fields + header + payload
  function automatic int msg_w(input int hdr_w, input int pay_w);
    return 32 + hdr_w + pay_w;
  endfunction

endpackage

// File: rtl/auth_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel strictly after
// ptr, wrapping modulo N_CH. ptr itself has the lowest priority.
module rr_arbiter
  import auth_request_arbiter_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CH_W = $clog2(N_CH)
)(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant_oh,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_any
);

  // Scan farthest-to-nearest so the nearest requester after ptr wins last
  always_comb begin
    logic [CH_W-1:0] cidx;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cidx      = '0;
    for (int i = N_CH; i >= 1; i--) begin
      cidx = CH_W'((int'(ptr) + i) % N_CH);
      if (req[cidx]) begin
        grant_oh       = '0;
        grant_oh[cidx] = 1'b1;
        grant_idx      = cidx;
        grant_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/auth_request_arbiter.sv
// N-channel authentication request arbiter: round-robin grant, role decode
// to responder/initiator engine, result framing (USB control or plain) and
// downstream presentation with ack timeout and bounded retry.
module auth_request_arbiter
  import auth_request_arbiter_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int HDR_W     = 32,
  parameter int PAY_W     = 256,
  parameter int ACK_TO    = 1024,
  parameter int MAX_RETRY = 2
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH-1:0]             req_valid,
  input  logic [8*N_CH-1:0]           req_desc,
  output logic [N_CH-1:0]             req_erase,
  output logic                        resp_en,
  output logic                        init_en,
  output logic [1:0]                  eng_slot,
  output logic [1:0]                  eng_type,
  input  logic                        eng_done,
  input  logic [HDR_W-1:0]            eng_hdr,
  input  logic [PAY_W-1:0]            eng_pay,
  input  logic [7:0]                  eng_bmrt,
  input  logic [7:0]                  eng_breq,
  input  logic [15:0]                 eng_wlen,
  output logic [32+HDR_W+PAY_W-1:0]   msg_out,
  output logic                        msg_valid,
  input  logic                        msg_ack,
  output logic [$clog2(N_CH)-1:0]     active_ch,
  output logic                        err_role,
  output logic                        err_timeout
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int MSG_W = msg_w(HDR_W, PAY_W);
  localparam int TMR_W = $clog2(ACK_TO);
  localparam int RTY_W = 3;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TO - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  logic [4:0]            state;
  logic [TMR_W-1:0]      timer;
  logic [RTY_W-1:0]      retries;
  logic [CH_W-1:0]       rr_ptr;
  logic [7:0]            desc_q;
  logic [N_CH-1:0][7:0]  desc_arr;
  logic [N_CH-1:0]       grant_oh;
  logic [CH_W-1:0]       grant_idx;
  logic                  grant_any;
  logic [MSG_W-1:0]      frame;
  logic [1:0]            role;
  logic [1:0]            usb;

  assign desc_arr = req_desc;
  assign role     = desc_q[ROLE_LSB +: 2];
  assign usb      = desc_q[USB_LSB +: 2];
  assign eng_slot = desc_q[SLOT_LSB +: 2];
  assign eng_type = desc_q[TYPE_LSB +: 2];

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Frame the engine result; USB control fields only when usb is non-zero
  always_comb begin
    frame = '0;
    if (usb == USB_NONE) frame = {32'b0, eng_hdr, eng_pay};
    else                 frame = {eng_bmrt, eng_breq, eng_hdr, eng_wlen, eng_pay};
  end

  // Transaction FSM: grant, decode, engine wait, send/retry, gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      retries     <= '0;
      rr_ptr      <= CH_W'(N_CH - 1);
      desc_q      <= '0;
      active_ch   <= '0;
      req_erase   <= '0;
      resp_en     <= 1'b0;
      init_en     <= 1'b0;
      msg_out     <= '0;
      msg_valid   <= 1'b0;
      err_role    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_erase   <= '0;
      err_role    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            desc_q    <= desc_arr[grant_idx];
            active_ch <= grant_idx;
            req_erase <= grant_oh;
            retries   <= '0;
            timer     <= '0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          timer <= '0;
          if (role == ROLE_RESP) begin
            resp_en <= 1'b1;
            state   <= ST_ENGINE;
          end else if (role == ROLE_INIT) begin
            init_en <= 1'b1;
            state   <= ST_ENGINE;
          end else begin
            err_role <= 1'b1;
            rr_ptr   <= active_ch;
            state    <= ST_IDLE;
          end
        end
        ST_ENGINE: begin
          if (eng_done) begin
            resp_en   <= 1'b0;
            init_en   <= 1'b0;
            msg_out   <= frame;
            msg_valid <= 1'b1;
            timer     <= '0;
            state     <= ST_SEND;
          end else if (timer == TMR_LAST) begin
            resp_en     <= 1'b0;
            init_en     <= 1'b0;
            err_timeout <= 1'b1;
            rr_ptr      <= active_ch;
            timer       <= '0;
            state       <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_SEND: begin
          // Ack beats expiry when both land in the same cycle
          if (msg_ack && msg_valid) begin
            msg_valid <= 1'b0;
            rr_ptr    <= active_ch;
            timer     <= '0;
            state     <= ST_IDLE;
          end else if (timer == TMR_LAST) begin
            msg_valid <= 1'b0;
            timer     <= '0;
            if (retries < RTY_MAX) begin
              retries <= retries + RTY_W'(1);
              state   <= ST_GAP;
            end else begin
              err_timeout <= 1'b1;
              rr_ptr      <= active_ch;
              state       <= ST_IDLE;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_GAP: begin
          msg_valid <= 1'b1;
          timer     <= '0;
          state     <= ST_SEND;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_request_arbiter.sv
// Scoreboard bench: driver predicts each transaction's events from the
// arbitration/retry rules and queues them; a monitor pops and compares as
// the DUT produces erase, engine start, message and error outputs.
module tb_auth_request_arbiter;

  localparam int NCH = 4;
  localparam int HW  = 16;
  localparam int PW  = 32;
  localparam int TO  = 8;
  localparam int MR  = 2;
  localparam int MW  = 32 + HW + PW;
  localparam int CW  = $clog2(NCH);

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req_valid;
  logic [8*NCH-1:0]  req_desc;
  logic [NCH-1:0]    req_erase;
  logic              resp_en, init_en;
  logic [1:0]        eng_slot, eng_type;
  logic              eng_done;
  logic [HW-1:0]     eng_hdr;
  logic [PW-1:0]     eng_pay;
  logic [7:0]        eng_bmrt, eng_breq;
  logic [15:0]       eng_wlen;
  logic [MW-1:0]     msg_out;
  logic              msg_valid;
  logic              msg_ack;
  logic [CW-1:0]     active_ch;
  logic              err_role, err_timeout;

  always #5 clk = ~clk;

  auth_request_arbiter #(
    .N_CH(NCH), .HDR_W(HW), .PAY_W(PW), .ACK_TO(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_desc(req_desc),
    .req_erase(req_erase), .resp_en(resp_en), .init_en(init_en),
    .eng_slot(eng_slot), .eng_type(eng_type), .eng_done(eng_done),
    .eng_hdr(eng_hdr), .eng_pay(eng_pay), .eng_bmrt(eng_bmrt),
    .eng_breq(eng_breq), .eng_wlen(eng_wlen), .msg_out(msg_out),
    .msg_valid(msg_valid), .msg_ack(msg_ack), .active_ch(active_ch),
    .err_role(err_role), .err_timeout(err_timeout)
  );

  typedef enum int {EV_ERASE, EV_EN, EV_ROLE, EV_MSG, EV_TO} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    int            ch;
    logic [7:0]    desc;
    logic [MW-1:0] msg;
    int            len;   // expected presentation length, 0 = not checked
  } ev_t;

  ev_t        expq[$];
  logic [7:0] chq[NCH][$];   // requester queues, front = presented descriptor
  int         last_ch;       // last served channel (round-robin pointer)
  int         errors = 0;
  int         checks = 0;

  function automatic ev_t mk_ev(ev_kind_e k, int ch, logic [7:0] d, logic [MW-1:0] m, int len);
    ev_t e;
    e.kind = k; e.ch = ch; e.desc = d; e.msg = m; e.len = len;
    return e;
  endfunction

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting for DUT", name);
    summary_and_finish();
  endtask

  task automatic pop_ev(input ev_kind_e k, input string name, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = mk_ev(EV_TO, 0, '0, '0, 0);
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL %s: got unexpected event %s, expected none", name, k.name());
    end else if (expq[0].kind != k) begin
      errors++;
      $display("FAIL %s: got event %s expected %s", name, k.name(), expq[0].kind.name());
    end else begin
      e  = expq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic apply_reqs();
    for (int c = 0; c < NCH; c++) begin
      req_valid[c] = (chq[c].size() > 0);
      req_desc[c*8 +: 8] = (chq[c].size() > 0) ? chq[c][0] : 8'($urandom);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queue
  initial begin
    ev_t           e;
    bit            ok;
    logic          mv_q = 1'b0, en_q = 1'b0, en_now;
    int            run = 0, cur_len = 0;
    logic [MW-1:0] cur_msg = '0;
    forever begin
      @(negedge clk);
      if (req_erase != '0) begin
        pop_ev(EV_ERASE, "erase", e, ok);
        if (ok) begin
          check("erase_onehot", MW'(req_erase), MW'(1 << e.ch));
          check("active_ch", MW'(active_ch), MW'(e.ch));
        end
      end
      en_now = resp_en | init_en;
      if (en_now && !en_q) begin
        pop_ev(EV_EN, "engine_start", e, ok);
        if (ok) begin
          check("resp_en", MW'(resp_en), MW'(e.desc[5:4] == 2'b01));
          check("init_en", MW'(init_en), MW'(e.desc[5:4] == 2'b10));
          check("eng_slot", MW'(eng_slot), MW'(e.desc[7:6]));
          check("eng_type", MW'(eng_type), MW'(e.desc[1:0]));
        end
      end
      en_q = en_now;
      if (err_role) pop_ev(EV_ROLE, "err_role", e, ok);
      if (msg_valid && !mv_q) begin
        pop_ev(EV_MSG, "msg_start", e, ok);
        if (ok) begin
          check("msg_out", msg_out, e.msg);
          cur_len = e.len;
          cur_msg = e.msg;
        end
        run = 1;
      end else if (msg_valid) begin
        run++;
        check("msg_stable", msg_out, cur_msg);
      end
      if (!msg_valid && mv_q && cur_len != 0) check("present_len", MW'(run), MW'(cur_len));
      mv_q = msg_valid;
      if (err_timeout) pop_ev(EV_TO, "err_timeout", e, ok);
    end
  end

  // One transaction: predict grant and outcome, then play engine/downstream.
  // d > TO means the engine never finishes; ack_pres > MR means never acked.
  task automatic run_txn(input int d, input int ack_pres, input int ack_at, input bit rst_send);
    int            g, c;
    logic [7:0]    dsc;
    logic [1:0]    role;
    bit            got, vrole;
    logic [MW-1:0] m;
    g = -1;
    for (int i = 1; i <= NCH; i++) begin
      c = (last_ch + i) % NCH;
      if (g < 0 && chq[c].size() > 0) g = c;
    end
    if (g < 0) return;
    dsc   = chq[g].pop_front();
    role  = dsc[5:4];
    vrole = (role == 2'b01) || (role == 2'b10);
    expq.push_back(mk_ev(EV_ERASE, g, dsc, '0, 0));
    if (vrole) expq.push_back(mk_ev(EV_EN, g, dsc, '0, 0));
    else       expq.push_back(mk_ev(EV_ROLE, g, dsc, '0, 0));
    if (vrole && d > TO) expq.push_back(mk_ev(EV_TO, g, dsc, '0, 0));
    got = 1'b0;
    for (int t = 0; t < 6 && !got; t++) begin
      @(negedge clk);
      got = (req_erase != '0);
    end
    if (!got) abort("erase_wait");
    apply_reqs();
    @(negedge clk);
    if (!vrole) begin
      check("role_drop_en", MW'(resp_en | init_en), MW'(0));
      last_ch = g;
      return;
    end
    if (d > TO) begin
      for (int n = 1; n <= TO; n++) begin
        check("en_hold", MW'(resp_en | init_en), MW'(1));
        @(negedge clk);
      end
      check("en_expire", MW'(resp_en | init_en), MW'(0));
      last_ch = g;
      return;
    end
    for (int n = 1; n < d; n++) begin
      check("en_hold", MW'(resp_en | init_en), MW'(1));
      @(negedge clk);
    end
    check("en_hold", MW'(resp_en | init_en), MW'(1));
    eng_hdr  = HW'($urandom);
    eng_pay  = PW'($urandom);
    eng_bmrt = 8'($urandom);
    eng_breq = 8'($urandom);
    eng_wlen = 16'($urandom);
    eng_done = 1'b1;
    if (dsc[3:2] != 2'b00) m = {eng_bmrt, eng_breq, eng_hdr, eng_wlen, eng_pay};
    else                   m = {32'b0, eng_hdr, eng_pay};
    if (rst_send) expq.push_back(mk_ev(EV_MSG, g, dsc, m, 0));
    else begin
      for (int p = 0; p <= MR && p <= ack_pres; p++)
        expq.push_back(mk_ev(EV_MSG, g, dsc, m, (p == ack_pres) ? ack_at : TO));
      if (ack_pres > MR) expq.push_back(mk_ev(EV_TO, g, dsc, '0, 0));
    end
    @(negedge clk);
    eng_done = 1'b0;
    eng_hdr  = HW'($urandom);
    eng_pay  = PW'($urandom);
    check("en_release", MW'(resp_en | init_en), MW'(0));
    for (int p = 0; p <= MR; p++) begin
      for (int k = 1; k <= TO; k++) begin
        check("msg_valid", MW'(msg_valid), MW'(1));
        if (rst_send && k == 2) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          check("rst_msg_valid", MW'(msg_valid), MW'(0));
          check("rst_erase", MW'(req_erase), MW'(0));
          check("rst_err", MW'({err_role, err_timeout}), MW'(0));
          last_ch = NCH - 1;
          return;
        end
        if (p == ack_pres && k == ack_at) msg_ack = 1'b1;
        @(negedge clk);
        msg_ack = 1'b0;
        if (p == ack_pres && k == ack_at) begin
          check("ack_release", MW'(msg_valid), MW'(0));
          last_ch = g;
          return;
        end
      end
      check("retry_gap", MW'(msg_valid), MW'(0));
      if (p < MR) begin
        msg_ack = 1'(($urandom % 2));   // must be ignored while not valid
        @(negedge clk);
        msg_ack = 1'b0;
      end
    end
    last_ch = g;
  endtask

  initial begin
    #400000;
    abort("watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_desc = '0; eng_done = 1'b0;
    eng_hdr = '0; eng_pay = '0; eng_bmrt = '0; eng_breq = '0; eng_wlen = '0;
    msg_ack = 1'b0; last_ch = NCH - 1;
    repeat (3) @(negedge clk);
    check("rst_erase", MW'(req_erase), MW'(0));
    check("rst_en", MW'({resp_en, init_en}), MW'(0));
    check("rst_msg", msg_out, '0);
    check("rst_valid", MW'(msg_valid), MW'(0));
    check("rst_active", MW'(active_ch), MW'(0));
    check("rst_errs", MW'({err_role, err_timeout}), MW'(0));
    reset = 1'b0;

    // responder, usb framing, done on 3rd cycle, ack on 2nd
    chq[0].push_back({2'd1, 2'b01, 2'b01, 2'd2});
    apply_reqs();
    run_txn(3, 0, 2, 1'b0);

    // reset during SEND on ch1; ch0 must win afterwards (ch2 would otherwise)
    chq[1].push_back({2'd2, 2'b01, 2'b10, 2'd1});
    chq[2].push_back({2'd3, 2'b10, 2'b11, 2'd0});
    chq[0].push_back({2'd0, 2'b10, 2'b01, 2'd3});
    apply_reqs();
    run_txn(2, 0, TO, 1'b1);
    run_txn(1, 0, 1, 1'b0);
    run_txn(2, 0, 1, 1'b0);
    chq[3].push_back({2'd1, 2'b01, 2'b00, 2'd1});
    apply_reqs();
    run_txn(1, 0, 3, 1'b0);

    // all channels held valid: 0,1,2,3,0
    chq[0].push_back({2'd0, 2'b01, 2'b01, 2'd0});
    chq[0].push_back({2'd3, 2'b10, 2'b00, 2'd3});
    chq[1].push_back({2'd1, 2'b10, 2'b10, 2'd1});
    chq[2].push_back({2'd2, 2'b01, 2'b11, 2'd2});
    chq[3].push_back({2'd3, 2'b01, 2'b00, 2'd0});
    apply_reqs();
    repeat (5) run_txn(2, 0, 1, 1'b0);

    // bad roles, never-acked retry exhaustion, ack on expiry, engine timeout
    chq[1].push_back({2'd2, 2'b11, 2'b01, 2'd1});
    chq[2].push_back({2'd1, 2'b00, 2'b00, 2'd2});
    chq[3].push_back({2'd0, 2'b01, 2'b10, 2'd3});
    chq[0].push_back({2'd3, 2'b10, 2'b00, 2'd1});
    chq[1].push_back({2'd1, 2'b01, 2'b01, 2'd0});
    chq[2].push_back({2'd2, 2'b10, 2'b10, 2'd2});
    apply_reqs();
    run_txn(1, 0, 1, 1'b0);
    run_txn(1, 0, 1, 1'b0);
    run_txn(2, MR + 1, 1, 1'b0);
    run_txn(1, 0, TO, 1'b0);
    run_txn(TO + 1, 0, 1, 1'b0);
    run_txn(TO, MR, TO, 1'b0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int tot;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        chq[$urandom_range(0, NCH - 1)].push_back(8'($urandom));
      tot = 0;
      for (int c = 0; c < NCH; c++) tot += chq[c].size();
      if (tot == 0) chq[$urandom_range(0, NCH - 1)].push_back(8'($urandom));
      apply_reqs();
      run_txn($urandom_range(1, TO + 1), $urandom_range(0, MR + 1),
              $urandom_range(1, TO), 1'b0);
    end

    for (int c = 0; c < NCH; c++) chq[c].delete();
    apply_reqs();
    repeat (4) @(negedge clk);
    check("events_drained", MW'(expq.size()), MW'(0));
    summary_and_finish();
  end

endmodule
